// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// fp_pkg : constants, flag indices and raw-mantissa layout for the FP adder
// Revision 1.0
// ============================================================================
package fp_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  // Bit positions inside the 4-bit {nan, overflow, underflow, zero} flag word
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_UNF  = 1;
  localparam int FLAG_OVF  = 2;
  localparam int FLAG_NAN  = 3;

  typedef struct packed {
    logic        carry;
    logic        hidden;
    logic [22:0] frac;
    logic        guard;
    logic        rnd;
  } raw_mant_t;

endpackage
`default_nettype wire

// File: rtl/fp_norm_round_if.sv
`default_nettype none
// ============================================================================
// fp_norm_round_if : valid/ready input beat and result bus of fp_norm_round
// Revision 1.0
// ============================================================================
interface fp_norm_round_if;
  import fp_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  raw_mant_t   in_mant;
  logic        in_sticky;
  logic        in_inf;
  logic        in_nan;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [3:0]  out_flags;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_sticky, in_inf, in_nan, out_ready,
    input  in_ready, out_valid, out_res, out_flags
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_sticky, in_inf, in_nan, out_ready,
    output in_ready, out_valid, out_res, out_flags
  );

endinterface
`default_nettype wire

// File: rtl/fp_lzc26.sv
`default_nettype none
// ============================================================================
// fp_lzc26 : combinational 26-bit leading-zero counter (all-zero input gives 25)
// Revision 1.0
// ============================================================================
module fp_lzc26 (
  input  logic [25:0] i_data,
  output logic [4:0]  o_lz
);

  // Ascending scan: the highest set bit is the last one to write the count
  always_comb begin
    o_lz = 5'd25;
    for (int i = 0; i < 26; i++) begin
      if (i_data[i]) o_lz = 5'(25 - i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_norm_round.sv
`default_nettype none
// ============================================================================
// fp_norm_round : two-stage normalise / round-to-nearest-even / pack stage
// Revision 1.0
// ============================================================================
module fp_norm_round
  import fp_pkg::*;
#(
  parameter int ROUND_EN = 1,
  parameter int FTZ      = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  fp_norm_round_if.slave bus
);

  localparam logic signed [9:0] c_exp_ovf = 10'(EXP_MAX);

  logic        rdy_q, rdy_d;
  logic        v1_q, v1_d;
  logic        sign1_q, sign1_d;
  logic        nan1_q, nan1_d;
  logic        inf1_q, inf1_d;
  logic        zero1_q, zero1_d;
  logic        sticky1_q, sticky1_d;
  logic [9:0]  exp1_q, exp1_d;
  logic [25:0] mant1_q, mant1_d;
  logic        v2_q, v2_d;
  logic [31:0] res_q, res_d;
  logic [3:0]  flags_q, flags_d;

  logic               w_ld1, w_ld2, w_acc;
  logic [4:0]         w_lz;
  logic               w_rup, w_tiny;
  logic [24:0]        w_rsum;
  logic signed [9:0]  w_rexp;
  logic [31:0]        w_pk_res;
  logic [3:0]         w_pk_flags;

  fp_lzc26 u_lzc (
    .i_data (bus.in_mant[25:0]),
    .o_lz   (w_lz)
  );

  // A stage loads when empty or when its contents move on this edge
  assign w_ld2         = !v2_q || bus.out_ready;
  assign w_ld1         = !v1_q || w_ld2;
  assign bus.in_ready  = rdy_q && w_ld1;
  assign w_acc         = bus.in_valid && bus.in_ready;
  assign bus.out_valid = v2_q;
  assign bus.out_res   = res_q;
  assign bus.out_flags = flags_q;
  assign rdy_d         = 1'b1;

  always_comb begin
    v1_d      = v1_q;
    sign1_d   = sign1_q;
    nan1_d    = nan1_q;
    inf1_d    = inf1_q;
    zero1_d   = zero1_q;
    sticky1_d = sticky1_q;
    exp1_d    = exp1_q;
    mant1_d   = mant1_q;
    if (w_ld1) v1_d = w_acc;
    if (w_acc) begin
      sign1_d   = bus.in_sign;
      nan1_d    = bus.in_nan;
      inf1_d    = bus.in_inf;
      zero1_d   = 1'b0;
      sticky1_d = bus.in_sticky;
      exp1_d    = '0;
      mant1_d   = '0;
      if (!(bus.in_nan || bus.in_inf)) begin
        if (bus.in_mant[26:0] == 27'd0 && !bus.in_sticky) begin
          zero1_d = 1'b1;
        end else if (bus.in_mant.carry) begin
          mant1_d   = bus.in_mant[26:1];
          sticky1_d = bus.in_sticky || bus.in_mant[0];
          exp1_d    = {2'b00, bus.in_exp} + 10'd1;
        end else begin
          mant1_d = bus.in_mant[25:0] << w_lz;
          exp1_d  = {2'b00, bus.in_exp} - {5'd0, w_lz};
        end
      end
    end
  end

  // mant1_q = {hidden, frac[22:0], guard, round}
  always_comb begin
    w_rup  = (ROUND_EN != 0) && mant1_q[1] && (mant1_q[0] || sticky1_q || mant1_q[2]);
    w_rsum = {1'b0, mant1_q[25:2]} + {24'd0, w_rup};
    w_rexp = exp1_q + {9'd0, w_rsum[24]};
    // A missing hidden bit can only come from a zero magnitude with sticky set
    w_tiny = (w_rexp <= 10'sd0) || !(w_rsum[24] || w_rsum[23]);
    w_pk_res   = {sign1_q, w_rexp[7:0], w_rsum[22:0]};
    w_pk_flags = '0;
    if (nan1_q) begin
      w_pk_res             = QNAN | {sign1_q, 31'd0};
      w_pk_flags[FLAG_NAN] = 1'b1;
    end else if (inf1_q) begin
      w_pk_res = POS_INF | {sign1_q, 31'd0};
    end else if (zero1_q) begin
      w_pk_res              = '0;
      w_pk_flags[FLAG_ZERO] = 1'b1;
    end else if (w_rexp >= c_exp_ovf) begin
      w_pk_res             = POS_INF | {sign1_q, 31'd0};
      w_pk_flags[FLAG_OVF] = 1'b1;
    end else if (w_tiny && (FTZ != 0)) begin
      w_pk_res              = {sign1_q, 31'd0};
      w_pk_flags[FLAG_UNF]  = 1'b1;
      w_pk_flags[FLAG_ZERO] = 1'b1;
    end
  end

  always_comb begin
    v2_d    = v2_q;
    res_d   = res_q;
    flags_d = flags_q;
    if (w_ld2) begin
      v2_d = v1_q;
      if (v1_q) begin
        res_d   = w_pk_res;
        flags_d = w_pk_flags;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q     <= 1'b0;
      v1_q      <= 1'b0;
      sign1_q   <= 1'b0;
      nan1_q    <= 1'b0;
      inf1_q    <= 1'b0;
      zero1_q   <= 1'b0;
      sticky1_q <= 1'b0;
      exp1_q    <= '0;
      mant1_q   <= '0;
      v2_q      <= 1'b0;
      res_q     <= '0;
      flags_q   <= '0;
    end else begin
      rdy_q     <= rdy_d;
      v1_q      <= v1_d;
      sign1_q   <= sign1_d;
      nan1_q    <= nan1_d;
      inf1_q    <= inf1_d;
      zero1_q   <= zero1_d;
      sticky1_q <= sticky1_d;
      exp1_q    <= exp1_d;
      mant1_q   <= mant1_d;
      v2_q      <= v2_d;
      res_q     <= res_d;
      flags_q   <= flags_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/fp_norm_round.md
Name: fp_norm_round

Overview:
- Downstream stage of the floating-point adder datapath. Consumes the raw sum produced by the mantissa adder: sign, larger exponent, and an un-normalised 27-bit magnitude with guard/round/sticky.
- Normalises the magnitude with a single-cycle leading-zero shift, rounds to nearest-even, and packs an IEEE-754 single.
- Two-stage valid/ready pipeline sustaining one result per cycle.

Parameters:
- ROUND_EN, 1, 1 = round-to-nearest-even; 0 = truncate (guard/round/sticky ignored).
- FTZ, 1, must be 1; results below the normal range are flushed to signed zero. 0 is reserved and not implemented.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat present
- in_ready  out  1  stage can accept a beat
- in_sign  in  1  result sign
- in_exp  in  8  biased exponent of larger operand
- in_mant  in  27  {carry, hidden, frac[22:0], guard, round}
- in_sticky  in  1  OR of bits shifted out during alignment
- in_inf  in  1  force signed infinity
- in_nan  in  1  force quiet NaN
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_res  out  32  packed IEEE-754 single
- out_flags  out  4  {nan, overflow, underflow, zero}

Behaviour:
- Reset (async, rst_n=0): both stage valid bits = 0, out_valid=0, out_res=0, out_flags=0. in_ready=1 from the first edge after release. In-flight beats are discarded.
- Handshake:
  - Input transfer on in_valid&in_ready. Output transfer on out_valid&out_ready.
  - Stage k advances when it is empty or stage k+1 advances. in_ready = !v1 | advance1 (combinational from out_ready).
  - out_res and out_flags hold stable while out_valid&!out_ready.
- Latency: 2 cycles, accept edge to out_valid. Throughput 1/cycle. Order is preserved.
- Stage 1 (normalise). Internal exponent is 10-bit signed.
  - in_nan or in_inf: bypass; mark the special case.
  - in_mant==0 & !in_sticky: zero; exp=0.
  - in_mant[26]=1: shift right 1; the dropped bit ORs into sticky; exp = in_exp+1.
  - Otherwise: lz = leading zeros of in_mant[25:0] (0..25); shift left lz; exp = in_exp-lz.
  - Register: mant[25:0], guard, round, sticky (sticky = in_sticky | bits below round), exp, sign, special bits.
- Stage 2 (round/pack):
  - lsb = frac[0]. round_up = ROUND_EN & guard & (round | sticky | lsb).
  - Add round_up to {hidden,frac}. On carry-out, frac=0 and exp+1.
  - exp >= 255 → ±inf (0x7F800000|sign<<31), overflow=1.
  - exp <= 0 → signed zero, underflow=1, zero=1.
  - nan → 0x7FC00000 with sign, nan=1. nan takes priority over inf.
  - True zero → 0x00000000 with sign bit = 0, zero=1.
  - Otherwise {sign, exp[7:0], frac}.
- Simultaneous input accept and output accept with the pipe full: both transfer and no bubble is inserted.
- Single-cycle assertions of in_valid with in_ready low are ignored. The upstream stage must hold its data until accepted.

Decomposition:
- Shared package fp_pkg:
  - Constants EXP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, POS_INF=32'h7F800000.
  - Flag bit indices.
  - Typedef for the 27-bit raw-mantissa layout.
- Sub-module fp_lzc26: combinational 26-bit leading-zero counter, 5-bit output.

Test Plan:
- Normal: in_exp=127, in_mant=27'h2000000 → out_res=0x3F800000, flags=0, out_valid exactly 2 cycles after accept.
- Carry: in_exp=127, in_mant=27'h4000000 → 0x40000000. Cancellation: in_exp=130, in_mant=27'h0000004 → 0x35800000.
- Rounding: in_exp=127, in_mant=27'h2000002 → 0x3F800000 (tie to even). in_mant=27'h2000006 → 0x3F800002. ROUND_EN=0 with 27'h2000006 → 0x3F800001.
- Overflow/underflow:
  - in_exp=254, in_mant=27'h7FFFFFF → 0x7F800000, overflow=1.
  - in_exp=3, in_mant=27'h0000004 → 0x00000000 with in_sign, underflow=1.
  - in_mant=0 → 0x00000000, zero=1.
- Specials: in_nan=1 → 0x7FC00000, nan=1. in_inf=1, sign=1 → 0xFF800000.
- Backpressure/reset:
  - Hold out_ready=0 and drive 3 beats: in_ready drops after 2 accepts; releasing out_ready delivers results in order with no loss.
  - Assert rst_n=0 mid-stream: out_valid=0 immediately; no stale result appears after reset release.
